crc32_fcs_appender: RTL and testbench



---
 rtl/crc32_fcs_appender_pkg.sv | 55 +++++
 rtl/crc32_fcs_appender_fcs_merge.sv | 39 +++
 rtl/crc32_fcs_appender.sv | 171 +++++++++++++++++
 tb/tb_crc32_fcs_appender.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc32_fcs_appender_pkg.sv
// Shared definitions for the CRC32 FCS appender.
//   - stream geometry constants (data/keep/checksum widths, FCS byte count)
//   - FSM state encoding
//   - helpers: keep-mask popcount, thermometer keep mask, FCS byte-lane merge
package crc32_fcs_appender_pkg;

    localparam int DATA_WIDTH = 256;
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int CRC_WIDTH  = 32;
    localparam int FCS_BYTES  = CRC_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(KEEP_WIDTH + 1);
    localparam int RES_WIDTH  = $clog2(FCS_BYTES + 1);

    typedef enum logic [1:0] {
        PASS       = 2'd0,
        WAIT_CRC   = 2'd1,
        EMIT_EXTRA = 2'd2
    } fsm_state_t;

    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        logic [CNT_WIDTH-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + CNT_WIDTH'(keep[i]);
        end
        return cnt;
    endfunction

    // Lowest 'count' bits set; count may range 0..KEEP_WIDTH+FCS_BYTES.
    function automatic logic [KEEP_WIDTH-1:0] keep_mask(input int count);
        logic [KEEP_WIDTH-1:0] mask;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            mask[i] = (i < count);
        end
        return mask;
    endfunction

    // Bytes below n come from data, bytes n..n+3 carry the checksum
    // (least significant byte first), everything above is zero.
    function automatic logic [DATA_WIDTH-1:0] merge_fcs(input logic [DATA_WIDTH-1:0] data,
                                                       input int n,
                                                       input logic [CRC_WIDTH-1:0] crc);
        logic [DATA_WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (i < n) begin
                res[i*8 +: 8] = data[i*8 +: 8];
            end else if (i - n < FCS_BYTES) begin
                res[i*8 +: 8] = 8'(crc >> (8 * (i - n)));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/crc32_fcs_appender_fcs_merge.sv
// Combinational FCS merge for the last beat of a frame.
//   hold_data      : stored last input beat
//   hold_count     : number of valid bytes in that beat (n)
//   crc            : checksum of the frame
//   merged_data/keep/last : beat to emit on the checksum handshake
//   residual_data/count   : FCS bytes that did not fit, right-aligned, and how many
module crc32_fcs_appender_fcs_merge
    import crc32_fcs_appender_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] hold_data,
    input  logic [CNT_WIDTH-1:0]  hold_count,
    input  logic [CRC_WIDTH-1:0]  crc,
    output logic [DATA_WIDTH-1:0] merged_data,
    output logic [KEEP_WIDTH-1:0] merged_keep,
    output logic                  merged_last,
    output logic [CRC_WIDTH-1:0]  residual_data,
    output logic [RES_WIDTH-1:0]  residual_count
);

    int n_bytes;

    always_comb begin
        n_bytes     = int'(hold_count);
        merged_data = merge_fcs(hold_data, n_bytes, crc);
        if (n_bytes <= KEEP_WIDTH - FCS_BYTES) begin
            merged_keep    = keep_mask(n_bytes + FCS_BYTES);
            merged_last    = 1'b1;
            residual_data  = '0;
            residual_count = '0;
        end else begin
            // Only KEEP_WIDTH-n FCS bytes fit; the rest spill into an extra beat.
            merged_keep    = '1;
            merged_last    = 1'b0;
            residual_data  = crc >> (8 * (KEEP_WIDTH - n_bytes));
            residual_count = RES_WIDTH'(n_bytes + FCS_BYTES - KEEP_WIDTH);
        end
    end

endmodule

// File: rtl/crc32_fcs_appender.sv
// Appends the 4-byte FCS to each AXI-Stream frame on the TX path.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   s_data_stream_*              : input frame (tdata/tkeep/tlast, valid/ready)
//   s_crc_stream_*               : one checksum per frame, in frame order
//   m_data_stream_*              : output frame with FCS appended
// Non-last beats pass through with one cycle latency; the last beat is held
// until its checksum arrives, then emitted with the FCS merged in, plus an
// extra beat when the FCS does not fit.
//
// state      | meaning
// PASS       | forwarding beats; last beat is captured into the hold register
// WAIT_CRC   | holding last beat, waiting for the checksum handshake
// EMIT_EXTRA | emitting the FCS bytes that spilled past the last beat
module crc32_fcs_appender
    import crc32_fcs_appender_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_data_stream_tvalid,
    output logic                  s_data_stream_tready,
    input  logic                  s_data_stream_tlast,
    input  logic [DATA_WIDTH-1:0] s_data_stream_tdata,
    input  logic [KEEP_WIDTH-1:0] s_data_stream_tkeep,
    input  logic                  s_crc_stream_valid,
    output logic                  s_crc_stream_ready,
    input  logic [CRC_WIDTH-1:0]  s_crc_stream_data,
    output logic                  m_data_stream_tvalid,
    input  logic                  m_data_stream_tready,
    output logic                  m_data_stream_tlast,
    output logic [DATA_WIDTH-1:0] m_data_stream_tdata,
    output logic [KEEP_WIDTH-1:0] m_data_stream_tkeep
);

    fsm_state_t state, state_nxt;

    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic [KEEP_WIDTH-1:0] out_keep;
    logic                  out_last;

    logic [DATA_WIDTH-1:0] hold_data;
    logic [CNT_WIDTH-1:0]  hold_count;
    logic [CRC_WIDTH-1:0]  res_data;
    logic [RES_WIDTH-1:0]  res_count;

    logic [DATA_WIDTH-1:0] merged_data;
    logic [KEEP_WIDTH-1:0] merged_keep;
    logic                  merged_last;
    logic [CRC_WIDTH-1:0]  merged_res_data;
    logic [RES_WIDTH-1:0]  merged_res_count;

    logic                  out_free;
    logic                  data_fire;
    logic                  crc_fire;
    logic                  load_out;
    logic [DATA_WIDTH-1:0] load_data;
    logic [KEEP_WIDTH-1:0] load_keep;
    logic                  load_last;

    crc32_fcs_appender_fcs_merge u_fcs_merge (
        .hold_data      (hold_data),
        .hold_count     (hold_count),
        .crc            (s_crc_stream_data),
        .merged_data    (merged_data),
        .merged_keep    (merged_keep),
        .merged_last    (merged_last),
        .residual_data  (merged_res_data),
        .residual_count (merged_res_count)
    );

    assign out_free  = !out_valid || m_data_stream_tready;
    assign data_fire = s_data_stream_tvalid && s_data_stream_tready;
    assign crc_fire  = s_crc_stream_valid && s_crc_stream_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PASS;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PASS:       if (data_fire && s_data_stream_tlast) state_nxt = WAIT_CRC;
            WAIT_CRC:   if (crc_fire) state_nxt = merged_last ? PASS : EMIT_EXTRA;
            EMIT_EXTRA: if (out_free) state_nxt = PASS;
            default:    state_nxt = PASS;
        endcase
    end

    always_comb begin
        s_data_stream_tready = 1'b0;
        s_crc_stream_ready   = 1'b0;
        load_out             = 1'b0;
        load_data            = '0;
        load_keep            = '0;
        load_last            = 1'b0;
        case (state)
            PASS: begin
                s_data_stream_tready = out_free;
                if (s_data_stream_tvalid && out_free && !s_data_stream_tlast) begin
                    load_out  = 1'b1;
                    load_data = s_data_stream_tdata;
                    load_keep = s_data_stream_tkeep;
                end
            end
            WAIT_CRC: begin
                s_crc_stream_ready = out_free;
                if (s_crc_stream_valid && out_free) begin
                    load_out  = 1'b1;
                    load_data = merged_data;
                    load_keep = merged_keep;
                    load_last = merged_last;
                end
            end
            EMIT_EXTRA: begin
                if (out_free) begin
                    load_out  = 1'b1;
                    load_data = DATA_WIDTH'(res_data);
                    load_keep = keep_mask(int'(res_count));
                    load_last = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // A beat that drains without a replacement clears only valid; the
    // stale payload is invisible while valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (m_data_stream_tready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_data  <= '0;
            hold_count <= '0;
            res_data   <= '0;
            res_count  <= '0;
        end else begin
            if (data_fire && s_data_stream_tlast) begin
                hold_data  <= s_data_stream_tdata;
                hold_count <= popcount(s_data_stream_tkeep);
            end
            if (crc_fire) begin
                res_data  <= merged_res_data;
                res_count <= merged_res_count;
            end
        end
    end

    assign m_data_stream_tvalid = out_valid;
    assign m_data_stream_tdata  = out_data;
    assign m_data_stream_tkeep  = out_keep;
    assign m_data_stream_tlast  = out_last;

endmodule

// File: tb/tb_crc32_fcs_appender.sv
// Self-checking bench for crc32_fcs_appender: a table of frames with
// hand-computed output beat counts and final keep masks, a byte-stream
// reference (payload followed by FCS bytes) for beat contents, and
// hand-written sequences for back-to-back timing and reset in WAIT_CRC.
module tb_crc32_fcs_appender;
    import crc32_fcs_appender_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tlast;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic [KEEP_WIDTH-1:0] s_tkeep;
    logic                  s_crc_valid;
    logic                  s_crc_ready;
    logic [CRC_WIDTH-1:0]  s_crc_data;
    logic                  m_tvalid;
    logic                  m_tready;
    logic                  m_tlast;
    logic [DATA_WIDTH-1:0] m_tdata;
    logic [KEEP_WIDTH-1:0] m_tkeep;

    always #5 clk = ~clk;

    crc32_fcs_appender dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .s_data_stream_tvalid (s_tvalid),
        .s_data_stream_tready (s_tready),
        .s_data_stream_tlast  (s_tlast),
        .s_data_stream_tdata  (s_tdata),
        .s_data_stream_tkeep  (s_tkeep),
        .s_crc_stream_valid   (s_crc_valid),
        .s_crc_stream_ready   (s_crc_ready),
        .s_crc_stream_data    (s_crc_data),
        .m_data_stream_tvalid (m_tvalid),
        .m_data_stream_tready (m_tready),
        .m_data_stream_tlast  (m_tlast),
        .m_data_stream_tdata  (m_tdata),
        .m_data_stream_tkeep  (m_tkeep)
    );

    typedef struct {
        int          len;
        logic [31:0] crc;
        int          fdly;
        int          cdly;
        bit          stall;
        bit          chk_lat;
        int          exp_beats;
        logic [31:0] exp_last_keep;
    } frame_t;

    frame_t tbl[10];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit stall_en = 1'b0;
    bit to_data = 1'b0;
    bit to_crc = 1'b0;
    int base = 0;

    logic [DATA_WIDTH-1:0] obs_data[512];
    logic [KEEP_WIDTH-1:0] obs_keep[512];
    logic                  obs_last[512];
    int                    obs_cyc[512];
    int                    obs_cnt = 0;

    logic [DATA_WIDTH-1:0] exp_data[16];
    logic [KEEP_WIDTH-1:0] exp_keep[16];
    logic                  exp_last[16];
    int                    exp_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n === 1'b1 && m_tvalid && m_tready && obs_cnt < 512) begin
            obs_data[obs_cnt] <= m_tdata;
            obs_keep[obs_cnt] <= m_tkeep;
            obs_last[obs_cnt] <= m_tlast;
            obs_cyc[obs_cnt]  <= cyc;
            obs_cnt           <= obs_cnt + 1;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [DATA_WIDTH-1:0] act,
                           input logic [DATA_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int fid, input int i);
        return 8'((fid * 37 + i * 11 + 5) & 255);
    endfunction

    // Reference: the output is the payload byte stream followed by the
    // checksum bytes (LSB first), cut into 32-byte beats, zero-padded.
    task automatic build_exp(input int len, input int fid, input logic [31:0] crc);
        int total;
        int idx;
        logic [7:0] byt;
        total = len + 4;
        exp_n = (total + 31) / 32;
        for (int b = 0; b < exp_n; b++) begin
            for (int j = 0; j < KEEP_WIDTH; j++) begin
                idx = b * 32 + j;
                if (idx < len) byt = pay(fid, idx);
                else if (idx < total) byt = 8'(crc >> (8 * (idx - len)));
                else byt = 8'h00;
                exp_data[b][j*8 +: 8] = byt;
                exp_keep[b][j] = (idx < total);
            end
            exp_last[b] = (b == exp_n - 1);
        end
    endtask

    task automatic send_frame(input int len, input int fid, input int fdly);
        int nb;
        int idx;
        bit got;
        logic [DATA_WIDTH-1:0] d;
        logic [KEEP_WIDTH-1:0] k;
        nb = (len == 0) ? 1 : (len + 31) / 32;
        repeat (fdly) begin
            @(posedge clk);
            #1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < KEEP_WIDTH; j++) begin
                idx = b * 32 + j;
                d[j*8 +: 8] = (idx < len) ? pay(fid, idx) : 8'hFF;
                k[j] = (idx < len);
            end
            s_tdata  = d;
            s_tkeep  = k;
            s_tlast  = (b == nb - 1);
            s_tvalid = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 1000; w++) begin
                @(negedge clk);
                if (s_tready) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                to_data = 1'b1;
                break;
            end
            if (b == nb - 1) acc_cyc = cyc;
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_crc(input logic [31:0] c, input int dly);
        bit got;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        s_crc_valid = 1'b1;
        s_crc_data  = c;
        got = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            @(negedge clk);
            if (s_crc_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) to_crc = 1'b1;
        else begin
            @(posedge clk);
            #1;
        end
        s_crc_valid = 1'b0;
    endtask

    task automatic cmp_exp(input string tag, input int at);
        for (int b = 0; b < exp_n; b++) begin
            if (at + b < obs_cnt) begin
                chk_vec($sformatf("%s_beat%0d_data", tag, b), obs_data[at+b], exp_data[b]);
                chk32($sformatf("%s_beat%0d_keep", tag, b), obs_keep[at+b], exp_keep[b]);
                chk32($sformatf("%s_beat%0d_last", tag, b), 32'(obs_last[at+b]), 32'(exp_last[b]));
            end
        end
    endtask

    task automatic wait_out(input int n);
        for (int k = 0; k < 3000 && obs_cnt < base + n; k++) @(posedge clk);
        stall_en = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic run_frame(input frame_t f, input int fid);
        string tag;
        tag = $sformatf("f%0d", fid);
        @(posedge clk);
        #1;
        stall_en = f.stall;
        base = obs_cnt;
        to_data = 1'b0;
        to_crc = 1'b0;
        build_exp(f.len, fid, f.crc);
        fork
            send_frame(f.len, fid, f.fdly);
            send_crc(f.crc, f.cdly);
        join
        chk32({tag, "_data_handshake"}, 32'(to_data), 32'd0);
        chk32({tag, "_crc_handshake"}, 32'(to_crc), 32'd0);
        wait_out(f.exp_beats);
        chk32({tag, "_beat_count"}, obs_cnt - base, f.exp_beats);
        if (obs_cnt > base) chk32({tag, "_last_keep"}, obs_keep[obs_cnt-1], f.exp_last_keep);
        cmp_exp(tag, base);
        if (f.chk_lat && obs_cnt > base) chk32({tag, "_latency"}, obs_cyc[base] - acc_cyc, 32'd2);
    endtask

    initial begin
        frame_t rf;
        reset_n     = 1'b0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_crc_valid = 1'b0;
        s_crc_data  = '0;

        //          len  crc           fdly cdly stall lat  beats last_keep
        tbl[0] = '{64,  32'hDEADBEEF, 0,   0,   1'b0, 1'b0, 3, 32'h0000000F};
        tbl[1] = '{40,  32'h11223344, 0,   0,   1'b0, 1'b0, 2, 32'h00000FFF};
        tbl[2] = '{62,  32'hA1B2C3D4, 0,   0,   1'b0, 1'b0, 3, 32'h00000003};
        tbl[3] = '{28,  32'h0BADF00D, 0,   0,   1'b0, 1'b1, 1, 32'hFFFFFFFF};
        tbl[4] = '{29,  32'h01020304, 0,   0,   1'b0, 1'b0, 2, 32'h00000001};
        tbl[5] = '{1,   32'hCAFEBABE, 0,   0,   1'b0, 1'b1, 1, 32'h0000001F};
        tbl[6] = '{62,  32'h5A5AA5A5, 6,   0,   1'b1, 1'b0, 3, 32'h00000003};
        tbl[7] = '{62,  32'h0F1E2D3C, 0,   12,  1'b1, 1'b0, 3, 32'h00000003};
        tbl[8] = '{100, 32'h87654321, 0,   3,   1'b1, 1'b0, 4, 32'h000000FF};
        tbl[9] = '{0,   32'h99AABBCC, 0,   0,   1'b0, 1'b0, 1, 32'h0000000F};

        repeat (3) @(posedge clk);
        #2;
        chk32("rst_tvalid", 32'(m_tvalid), 32'd0);
        chk_vec("rst_tdata", m_tdata, '0);
        chk32("rst_tkeep", m_tkeep, 32'd0);
        chk32("rst_tlast", 32'(m_tlast), 32'd0);
        chk32("rst_s_tready", 32'(s_tready), 32'd1);
        chk32("rst_crc_ready", 32'(s_crc_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_frame(tbl[i], i);

        // Back-to-back 32-byte frames, checksums already waiting.
        @(posedge clk);
        #1;
        stall_en = 1'b0;
        base = obs_cnt;
        fork
            begin
                send_frame(32, 20, 0);
                send_frame(32, 21, 0);
            end
            begin
                send_crc(32'hFEEDC0DE, 0);
                send_crc(32'h13579BDF, 0);
            end
        join
        wait_out(4);
        chk32("b2b_beat_count", obs_cnt - base, 32'd4);
        build_exp(32, 20, 32'hFEEDC0DE);
        cmp_exp("b2b_a", base);
        build_exp(32, 21, 32'h13579BDF);
        cmp_exp("b2b_b", base + 2);
        if (obs_cnt >= base + 4) begin
            chk32("b2b_gap_a", obs_cyc[base+1] - obs_cyc[base], 32'd1);
            chk32("b2b_gap_ab", obs_cyc[base+2] - obs_cyc[base+1], 32'd2);
            chk32("b2b_gap_b", obs_cyc[base+3] - obs_cyc[base+2], 32'd1);
        end

        // Reset while waiting for a checksum.
        @(posedge clk);
        #1;
        to_data = 1'b0;
        send_frame(40, 30, 0);
        #1;
        chk32("wait_crc_ready", 32'(s_crc_ready), 32'd1);
        chk32("wait_data_ready", 32'(s_tready), 32'd0);
        reset_n = 1'b0;
        #1;
        chk32("midrst_tvalid", 32'(m_tvalid), 32'd0);
        chk_vec("midrst_tdata", m_tdata, '0);
        chk32("midrst_tkeep", m_tkeep, 32'd0);
        chk32("midrst_crc_ready", 32'(s_crc_ready), 32'd0);
        chk32("midrst_s_tready", 32'(s_tready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        rf = '{40, 32'h11223344, 0, 0, 1'b0, 1'b0, 2, 32'h00000FFF};
        run_frame(rf, 31);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
